multiplayer_link: RTL

- Point-to-point serial link between two game boards. It produces the `opponent_ready` and `victory` inputs of the game core.
- Periodically transmits this board's status (`player_ready`, `game_over`) as an 8N1 UART frame on `tx`.
- Decodes the opponent's frames on `rx`.
- Supervises link health with a timeout. Sits upstream of the game core, between the board pins and the core's status inputs.

---
 rtl/multiplayer_link_if.sv | 23 ++
 rtl/multiplayer_link.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplayer_link_if.sv
// Status and serial-pin signals exchanged between the board pins, the game core and the link.
// The slave modport is the link's view; the master modport is its environment's view.
interface multiplayer_link_if;
    logic multiplayer;
    logic player_ready;
    logic game_over;
    logic rx;
    logic tx;
    logic opponent_ready;
    logic victory;
    logic link_up;
    logic rx_error;

    modport master (
        output multiplayer, player_ready, game_over, rx,
        input  tx, opponent_ready, victory, link_up, rx_error
    );

    modport slave (
        input  multiplayer, player_ready, game_over, rx,
        output tx, opponent_ready, victory, link_up, rx_error
    );
endinterface

// File: rtl/multiplayer_link.sv
// Point-to-point 8N1 status link: periodic status frames out on tx, opponent frames decoded
// from rx, with link-health timeout and sticky victory detection.
module multiplayer_link #(
    parameter int CLKS_PER_BIT = 564,
    parameter int TX_INTERVAL  = 65000,
    parameter int LINK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    multiplayer_link_if.slave link
);
    localparam int BIT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int INT_W     = $clog2(TX_INTERVAL + 1);
    localparam int TMO_LIMIT = LINK_TIMEOUT * TX_INTERVAL;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [INT_W-1:0] INT_LAST  = INT_W'(TX_INTERVAL - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TMO_LIMIT);
    localparam logic [TMO_W-1:0] TMO_EDGE  = TMO_W'(TMO_LIMIT - 1);
    localparam logic [5:0]       HEADER    = 6'b101_000;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- launch interval ----------------
    logic [INT_W-1:0] int_cnt_q, int_cnt_d;
    logic             int_wrap;

    always_comb begin
        int_wrap  = (int_cnt_q == INT_LAST);
        int_cnt_d = int_wrap ? '0 : int_cnt_q + INT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) int_cnt_q <= '0;
        else      int_cnt_q <= int_cnt_d;
    end

    // ---------------- transmitter ----------------
    state_t           tx_state_q;
    logic [BIT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_idx_q;
    logic [7:0]       tx_shift_q;
    logic             tx_q;
    logic             tx_bit_done;

    assign tx_bit_done = (tx_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    tx_q     <= 1'b1;
                    tx_cnt_q <= '0;
                    // A launch that falls while a frame is in flight is simply dropped.
                    if (int_wrap && link.multiplayer) begin
                        tx_shift_q <= {3'b101, 3'b000, link.game_over, link.player_ready};
                        tx_state_q <= START;
                        tx_q       <= 1'b0;
                    end
                end
                START: begin
                    if (tx_bit_done) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (tx_bit_done) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= STOP;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (tx_bit_done) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + BIT_W'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= link.rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    state_t           rx_state_q;
    logic [BIT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_idx_q;
    logic [7:0]       rx_shift_q;
    logic             rx_bit_done;

    assign rx_bit_done = (rx_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else if (!link.multiplayer) begin
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
        end else begin
            case (rx_state_q)
                IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_fall) rx_state_q <= START;
                end
                START: begin
                    // Half-bit wait lands later samples mid-bit; a high line here is a glitch.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        rx_state_q <= rx_s2_q ? IDLE : DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (rx_bit_done) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) rx_state_q <= STOP;
                        else                  rx_idx_q   <= rx_idx_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (rx_bit_done) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + BIT_W'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- status outputs ----------------
    logic             rx_stop_sample, rx_frame_ok, rx_frame_bad;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             opp_ready_q, victory_q, link_up_q, rx_error_q;

    always_comb begin
        rx_stop_sample = (rx_state_q == STOP) && rx_bit_done;
        rx_frame_ok    = rx_stop_sample && rx_s2_q && (rx_shift_q[7:2] == HEADER);
        rx_frame_bad   = rx_stop_sample && !rx_frame_ok;
        tmo_d          = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst || !link.multiplayer) begin
            tmo_q       <= '0;
            opp_ready_q <= 1'b0;
            victory_q   <= 1'b0;
            link_up_q   <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            rx_error_q <= rx_frame_bad;
            if (rx_frame_ok) begin
                tmo_q       <= '0;
                opp_ready_q <= rx_shift_q[0];
                link_up_q   <= 1'b1;
                // A local loss in the same cycle beats the opponent's loss.
                if (rx_shift_q[1] && !link.game_over) victory_q <= 1'b1;
            end else begin
                tmo_q <= tmo_d;
                // Drop on the edge the counter reaches the limit, not one cycle after.
                if (tmo_q >= TMO_EDGE) begin
                    link_up_q   <= 1'b0;
                    opp_ready_q <= 1'b0;
                end
            end
        end
    end

    assign link.tx             = tx_q;
    assign link.opponent_ready = opp_ready_q;
    assign link.victory        = victory_q;
    assign link.link_up        = link_up_q;
    assign link.rx_error       = rx_error_q;
endmodule
